// File: rtl/usb_bus_regif.sv
// SAM3U parallel-bus front end: samples USB_* pins, detects strobe edges and issues
// single-cycle register read/write strobes, read-data return and fast-FIFO pops.
module usb_bus_regif #(
  parameter int unsigned pRD_LATENCY = 2,
  parameter logic [7:0]  pFAST_ADDR  = 8'd3
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic [7:0] USB_Addr,
  input  logic [6:0] USB_Addr_Bytecount,
  input  logic       USB_RDn,
  input  logic       USB_WRn,
  input  logic       USB_CEn,
  input  logic [7:0] USB_Din,
  output logic [7:0] USB_Dout,
  output logic       USB_Dout_oe,
  output logic [7:0] reg_address,
  output logic [6:0] reg_bytecnt,
  output logic [7:0] reg_datao,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_datai,
  output logic       fast_fifo_read,
  output logic       bus_error
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BCNT_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } state_t;

  // Stage A: raw pin samples; stage B: one-cycle delayed strobes for edge detect
  logic              a_rdn_q, a_wrn_q, a_cen_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [BCNT_W-1:0] a_bcnt_q;
  logic [DATA_W-1:0] a_din_q;
  logic              b_rdn_q, b_wrn_q;

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      a_rdn_q  <= 1'b1;
      a_wrn_q  <= 1'b1;
      a_cen_q  <= 1'b1;
      a_addr_q <= '0;
      a_bcnt_q <= '0;
      a_din_q  <= '0;
      b_rdn_q  <= 1'b1;
      b_wrn_q  <= 1'b1;
    end else begin
      a_rdn_q  <= USB_RDn;
      a_wrn_q  <= USB_WRn;
      a_cen_q  <= USB_CEn;
      a_addr_q <= USB_Addr;
      a_bcnt_q <= USB_Addr_Bytecount;
      a_din_q  <= USB_Din;
      b_rdn_q  <= a_rdn_q;
      b_wrn_q  <= a_wrn_q;
    end
  end

  logic wr_edge_c, rd_edge_c, both_low_c, released_c;
  assign wr_edge_c  = !a_wrn_q && b_wrn_q && !a_cen_q;
  assign rd_edge_c  = !a_rdn_q && b_rdn_q && !a_cen_q;
  assign both_low_c = !a_rdn_q && !a_wrn_q && !a_cen_q;
  assign released_c = a_rdn_q || a_cen_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] reg_address_q, reg_address_d;
  logic [BCNT_W-1:0] reg_bytecnt_q, reg_bytecnt_d;
  logic [DATA_W-1:0] reg_datao_q, reg_datao_d;
  logic [DATA_W-1:0] usb_dout_q, usb_dout_d;
  logic              usb_dout_oe_q, usb_dout_oe_d;
  logic              reg_write_q, reg_write_d;
  logic              reg_read_q, reg_read_d;
  logic              fast_fifo_read_q, fast_fifo_read_d;
  logic              bus_error_q, bus_error_d;

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      reg_address_q    <= '0;
      reg_bytecnt_q    <= '0;
      reg_datao_q      <= '0;
      usb_dout_q       <= '0;
      usb_dout_oe_q    <= 1'b0;
      reg_write_q      <= 1'b0;
      reg_read_q       <= 1'b0;
      fast_fifo_read_q <= 1'b0;
      bus_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      reg_address_q    <= reg_address_d;
      reg_bytecnt_q    <= reg_bytecnt_d;
      reg_datao_q      <= reg_datao_d;
      usb_dout_q       <= usb_dout_d;
      usb_dout_oe_q    <= usb_dout_oe_d;
      reg_write_q      <= reg_write_d;
      reg_read_q       <= reg_read_d;
      fast_fifo_read_q <= fast_fifo_read_d;
      bus_error_q      <= bus_error_d;
    end
  end

  // Access sequencing; the latency count is checked before decrement, so data is
  // latched on the edge where the count reaches zero.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    reg_address_d    = reg_address_q;
    reg_bytecnt_d    = reg_bytecnt_q;
    reg_datao_d      = reg_datao_q;
    usb_dout_d       = usb_dout_q;
    usb_dout_oe_d    = usb_dout_oe_q;
    reg_write_d      = 1'b0;
    reg_read_d       = 1'b0;
    fast_fifo_read_d = 1'b0;
    bus_error_d      = bus_error_q;

    if (both_low_c) begin
      bus_error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (wr_edge_c && rd_edge_c) begin
          bus_error_d = 1'b1;
        end else if (wr_edge_c && a_rdn_q) begin
          reg_write_d   = 1'b1;
          reg_address_d = a_addr_q;
          reg_bytecnt_d = a_bcnt_q;
          reg_datao_d   = a_din_q;
        end else if (rd_edge_c && a_wrn_q) begin
          reg_read_d    = 1'b1;
          reg_address_d = a_addr_q;
          reg_bytecnt_d = a_bcnt_q;
          usb_dout_oe_d = 1'b1;
          cnt_d         = CNT_W'(pRD_LATENCY);
          state_d       = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (wr_edge_c) begin
          bus_error_d = 1'b1;
        end
        if (released_c) begin
          usb_dout_oe_d = 1'b0;
          bus_error_d   = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d      = '0;
          usb_dout_d = reg_datai;
          // Prefetch the next streaming word as soon as the current one is captured
          if (reg_address_q == pFAST_ADDR) begin
            fast_fifo_read_d = 1'b1;
          end
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RD_HOLD: begin
        if (wr_edge_c) begin
          bus_error_d = 1'b1;
        end
        if (released_c) begin
          usb_dout_oe_d = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        usb_dout_oe_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  assign USB_Dout       = usb_dout_q;
  assign USB_Dout_oe    = usb_dout_oe_q;
  assign reg_address    = reg_address_q;
  assign reg_bytecnt    = reg_bytecnt_q;
  assign reg_datao      = reg_datao_q;
  assign reg_write      = reg_write_q;
  assign reg_read       = reg_read_q;
  assign fast_fifo_read = fast_fifo_read_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_usb_bus_regif.sv
// Self-checking bench for usb_bus_regif: per-feature tasks plus a strobe scoreboard.
module tb_usb_bus_regif;

  localparam int unsigned LAT = 2;
  localparam logic [7:0]  FAST = 8'd3;

  logic       clk_usb = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] USB_Addr = '0;
  logic [6:0] USB_Addr_Bytecount = '0;
  logic       USB_RDn = 1'b1;
  logic       USB_WRn = 1'b1;
  logic       USB_CEn = 1'b1;
  logic [7:0] USB_Din = '0;
  logic [7:0] USB_Dout;
  logic       USB_Dout_oe;
  logic [7:0] reg_address;
  logic [6:0] reg_bytecnt;
  logic [7:0] reg_datao;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_datai;
  logic       fast_fifo_read;
  logic       bus_error;

  usb_bus_regif #(.pRD_LATENCY(LAT), .pFAST_ADDR(FAST)) dut (
    .clk_usb(clk_usb), .reset(reset),
    .USB_Addr(USB_Addr), .USB_Addr_Bytecount(USB_Addr_Bytecount),
    .USB_RDn(USB_RDn), .USB_WRn(USB_WRn), .USB_CEn(USB_CEn),
    .USB_Din(USB_Din), .USB_Dout(USB_Dout), .USB_Dout_oe(USB_Dout_oe),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
    .reg_write(reg_write), .reg_read(reg_read), .reg_datai(reg_datai),
    .fast_fifo_read(fast_fifo_read), .bus_error(bus_error)
  );

  always #5 clk_usb = ~clk_usb;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int ffr_cnt = 0;

  // Scoreboards: expected {addr,bcnt,data} per write, addr per read, data per read return
  logic [22:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_data[$];

  // Register decoder model: plain register value or streaming FIFO with prefetch pop
  logic [7:0] rd_val = '0;
  logic       fast_sel = 1'b0;
  logic [7:0] fifo_mem[4];
  int         fptr = 0;
  assign reg_datai = fast_sel ? fifo_mem[fptr % 4] : rd_val;

  always @(posedge clk_usb) begin
    if (fast_fifo_read) fptr <= fptr + 1;
  end

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk_usb) begin
    if (reg_write) begin
      wr_pulses++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h bcnt=%h data=%h, required no write", reg_address, reg_bytecnt, reg_datao);
      end else begin
        logic [22:0] e;
        e = exp_wr.pop_front();
        if ({reg_address, reg_bytecnt, reg_datao} !== e) begin
          errors++;
          $display("FAIL write_payload: got %h/%h/%h, required %h/%h/%h", reg_address, reg_bytecnt, reg_datao, e[22:15], e[14:8], e[7:0]);
        end
      end
    end
    if (reg_read) begin
      rd_pulses++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got addr=%h, required no read", reg_address);
      end else begin
        logic [7:0] ea;
        ea = exp_rd.pop_front();
        if (reg_address !== ea) begin
          errors++;
          $display("FAIL read_addr: got %h, required %h", reg_address, ea);
        end
      end
    end
    if (fast_fifo_read) ffr_cnt++;
  end

  task automatic step();
    @(posedge clk_usb);
    #1;
  endtask

  // Full read transaction: RDn low 6 cycles, checks strobe, oe, data latency and oe release
  task automatic read_txn(input logic [7:0] a);
    logic [7:0] ed;
    USB_Addr = a; USB_Addr_Bytecount = 7'd0;
    USB_RDn = 1'b0; USB_CEn = 1'b0;
    exp_rd.push_back(a);
    step();  // edge k
    checks++;
    if (USB_Dout_oe !== 1'b0 || reg_read !== 1'b0) begin
      errors++; $display("FAIL rd_k_idle: oe=%b read=%b, required 0/0", USB_Dout_oe, reg_read);
    end
    step();  // k+1
    checks++;
    if (reg_read !== 1'b1 || USB_Dout_oe !== 1'b1) begin
      errors++; $display("FAIL rd_k1_strobe: read=%b oe=%b, required 1/1", reg_read, USB_Dout_oe);
    end
    step();  // k+2
    checks++;
    if (reg_read !== 1'b0) begin
      errors++; $display("FAIL rd_k2_single: read=%b, required 0", reg_read);
    end
    step();  // k+3 = k+1+LAT
    ed = exp_data.pop_front();
    checks++;
    if (USB_Dout !== ed || USB_Dout_oe !== 1'b1) begin
      errors++; $display("FAIL rd_data: dout=%h oe=%b, required %h/1", USB_Dout, USB_Dout_oe, ed);
    end
    step(); step();  // k+5
    USB_RDn = 1'b1; USB_CEn = 1'b1;
    step();  // k+6
    checks++;
    if (USB_Dout_oe !== 1'b1) begin
      errors++; $display("FAIL rd_oe_hold: oe=%b, required 1", USB_Dout_oe);
    end
    step();  // k+7
    checks++;
    if (USB_Dout_oe !== 1'b0 || USB_Dout !== ed) begin
      errors++; $display("FAIL rd_oe_drop: oe=%b dout=%h, required 0/%h", USB_Dout_oe, USB_Dout, ed);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({USB_Dout, USB_Dout_oe, reg_address, reg_bytecnt, reg_datao, reg_write, reg_read,
         fast_fifo_read, bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h oe=%b addr=%h bcnt=%h datao=%h wr=%b rd=%b ffr=%b err=%b, required all 0",
               USB_Dout, USB_Dout_oe, reg_address, reg_bytecnt, reg_datao, reg_write, reg_read, fast_fifo_read, bus_error);
    end
    reset = 1'b0;
    step(); step();
  endtask

  task automatic write_txn(input logic [7:0] a, input logic [6:0] b, input logic [7:0] d);
    int rd0;
    rd0 = rd_pulses;
    USB_Addr = a; USB_Addr_Bytecount = b; USB_Din = d;
    USB_WRn = 1'b0; USB_CEn = 1'b0;
    exp_wr.push_back({a, b, d});
    step();  // edge k
    checks++;
    if (reg_write !== 1'b0) begin
      errors++; $display("FAIL wr_k_early: write=%b, required 0", reg_write);
    end
    step();  // k+1
    checks++;
    if (reg_write !== 1'b1 || reg_address !== a || reg_bytecnt !== b || reg_datao !== d) begin
      errors++; $display("FAIL wr_k1: write=%b %h/%h/%h, required 1 %h/%h/%h", reg_write, reg_address, reg_bytecnt, reg_datao, a, b, d);
    end
    step();  // k+2
    USB_WRn = 1'b1; USB_CEn = 1'b1; USB_Din = 8'h00;
    checks++;
    if (reg_write !== 1'b0 || reg_datao !== d) begin
      errors++; $display("FAIL wr_k2: write=%b datao=%h, required 0/%h", reg_write, reg_datao, d);
    end
    step(); step(); step();
    checks++;
    if (rd_pulses != rd0) begin
      errors++; $display("FAIL wr_no_read: read pulses=%0d, required %0d", rd_pulses, rd0);
    end
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_pulses;
    write_txn(8'h12, 7'd5, 8'hA5);
    write_txn(8'hFE, 7'h7F, 8'h5A);
    checks++;
    if (wr_pulses != w0 + 2) begin
      errors++; $display("FAIL wr_count: pulses=%0d, required %0d", wr_pulses - w0, 2);
    end
  endtask

  task automatic test_read();
    int f0;
    f0 = ffr_cnt;
    fast_sel = 1'b0; rd_val = 8'h3C;
    exp_data.push_back(8'h3C);
    read_txn(8'h20);
    checks++;
    if (ffr_cnt != f0) begin
      errors++; $display("FAIL rd_no_pop: pops=%0d, required 0", ffr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back_fast();
    int f0;
    f0 = ffr_cnt;
    fifo_mem[0] = 8'h11; fifo_mem[1] = 8'h22; fifo_mem[2] = 8'h33; fifo_mem[3] = 8'h44;
    fptr = 0;
    fast_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_data.push_back(fifo_mem[i]);
      read_txn(FAST);
    end
    checks++;
    if (ffr_cnt != f0 + 4) begin
      errors++; $display("FAIL fast_pops: pops=%0d, required 4", ffr_cnt - f0);
    end
    fast_sel = 1'b0;
  endtask

  task automatic test_abort();
    int f0;
    f0 = ffr_cnt;
    rd_val = 8'h99;
    USB_Addr = FAST; USB_RDn = 1'b0; USB_CEn = 1'b0;
    fast_sel = 1'b0;
    exp_rd.push_back(FAST);
    step();  // k
    step();  // k+1
    USB_RDn = 1'b1; USB_CEn = 1'b1;
    step();  // k+2: release sampled
    checks++;
    if (USB_Dout_oe !== 1'b1 || bus_error !== 1'b0) begin
      errors++; $display("FAIL abort_k2: oe=%b err=%b, required 1/0", USB_Dout_oe, bus_error);
    end
    step();  // k+3
    checks++;
    if (USB_Dout_oe !== 1'b0 || bus_error !== 1'b1 || USB_Dout !== 8'h44) begin
      errors++; $display("FAIL abort_k3: oe=%b err=%b dout=%h, required 0/1/44", USB_Dout_oe, bus_error, USB_Dout);
    end
    step(); step();
    checks++;
    if (ffr_cnt != f0 || bus_error !== 1'b1) begin
      errors++; $display("FAIL abort_after: pops=%0d err=%b, required 0/1", ffr_cnt - f0, bus_error);
    end
  endtask

  task automatic test_reset_mid_read();
    int f0;
    f0 = ffr_cnt;
    fifo_mem[0] = 8'hC1; fifo_mem[1] = 8'hC2; fifo_mem[2] = 8'hC3; fifo_mem[3] = 8'hC4;
    fptr = 0;
    fast_sel = 1'b1;
    USB_Addr = FAST; USB_RDn = 1'b0; USB_CEn = 1'b0;
    exp_rd.push_back(FAST);
    step();  // k
    step();  // k+1
    reset = 1'b1;
    step();  // k+2 reset edge
    checks++;
    if (USB_Dout_oe !== 1'b0 || USB_Dout !== 8'h00 || bus_error !== 1'b0 || reg_read !== 1'b0) begin
      errors++; $display("FAIL midrst: oe=%b dout=%h err=%b rd=%b, required 0/00/0/0", USB_Dout_oe, USB_Dout, bus_error, reg_read);
    end
    USB_RDn = 1'b1; USB_CEn = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if (ffr_cnt != f0 || fast_fifo_read !== 1'b0) begin
      errors++; $display("FAIL midrst_pop: pops=%0d, required 0", ffr_cnt - f0);
    end
    fast_sel = 1'b0; rd_val = 8'h5A;
    exp_data.push_back(8'h5A);
    read_txn(8'h21);
  endtask

  task automatic test_both_low();
    int w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    USB_Addr = 8'h30; USB_RDn = 1'b0; USB_WRn = 1'b0; USB_CEn = 1'b0;
    step(); step();  // k+1
    checks++;
    if (bus_error !== 1'b1 || reg_write !== 1'b0 || reg_read !== 1'b0 || USB_Dout_oe !== 1'b0) begin
      errors++; $display("FAIL both_low: err=%b wr=%b rd=%b oe=%b, required 1/0/0/0", bus_error, reg_write, reg_read, USB_Dout_oe);
    end
    step();
    USB_RDn = 1'b1; USB_WRn = 1'b1; USB_CEn = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus_error !== 1'b1 || wr_pulses != w0 || rd_pulses != r0) begin
      errors++; $display("FAIL both_low_sticky: err=%b wr=%0d rd=%0d, required 1/0/0", bus_error, wr_pulses - w0, rd_pulses - r0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back_fast();
    test_abort();
    test_reset_mid_read();
    test_both_low();
    test_reset();
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_data.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: wr=%0d rd=%0d data=%0d left, required 0", exp_wr.size(), exp_rd.size(), exp_data.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

endmodule

// File: doc/usb_bus_regif.md
# usb_bus_regif

Front-end stage that converts the SAM3U parallel bus (the USB_* pins of the Husky/CW310 top) into single-cycle register read/write strobes for the register decoders. It samples the bus on clk_usb, detects strobe edges, issues `reg_write`/`reg_read` pulses with address, bytecount and data, and returns read data with an output enable for the top-level tri-state on USB_Data. It also generates the pop pulse for the fast-read streaming FIFO.

## Interface
Parameters:
- pRD_LATENCY, 2: cycles from `reg_read` pulse to `reg_datai` being valid (1..7).
- pFAST_ADDR, 8'd3: register address that triggers `fast_fifo_read`.

Ports (one clock; reset is synchronous and active-high):
- clk_usb  in  1  bus/system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- USB_Addr  in  8  register address from SAM3U.
- USB_Addr_Bytecount  in  7  byte offset within the multi-byte register.
- USB_RDn  in  1  read strobe, active-low.
- USB_WRn  in  1  write strobe, active-low.
- USB_CEn  in  1  chip enable, active-low.
- USB_Din  in  8  input side of USB_Data pad.
- USB_Dout  out  8  read data to pad.
- USB_Dout_oe  out  1  pad output enable.
- reg_address  out  8  captured address.
- reg_bytecnt  out  7  captured bytecount.
- reg_datao  out  8  captured write data.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read request.
- reg_datai  in  8  read data from register decoders.
- fast_fifo_read  out  1  one-cycle FIFO pop.
- bus_error  out  1  sticky protocol-error flag.

## Operation
- Stage A registers USB_RDn/WRn/CEn/Addr/Bytecount/Din every cycle; stage B delays A's strobes by one cycle. Reset sets A/B strobe bits to 1 (inactive) so no false edge follows reset.
- Write edge: A.WRn=0, B.WRn=1, A.CEn=0. Read edge: same with RDn.
- FSM states IDLE, RD_WAIT, RD_HOLD.
- IDLE + write edge (RDn high in A): `reg_write`=1 for one cycle; `reg_address`, `reg_bytecnt`, `reg_datao` loaded from A on the same edge and held until the next accepted access.
- IDLE + read edge (WRn high in A): `reg_read`=1 one cycle, address/bytecount loaded, `USB_Dout_oe`=1, latency counter loaded with pRD_LATENCY, go RD_WAIT.
- RD_WAIT: counter decrements each cycle; at 0 latch `reg_datai` into `USB_Dout`; if `reg_address`==pFAST_ADDR pulse `fast_fifo_read` on that same edge (prefetch next word); go RD_HOLD.
- RD_HOLD: hold `USB_Dout`; when A.RDn=1 or A.CEn=1, clear `USB_Dout_oe`, go IDLE.
- RD_WAIT with A.RDn=1 or A.CEn=1 (aborted read): clear oe, go IDLE, no data latch, no FIFO pop.
- Errors, setting `bus_error` (cleared only by reset): RDn and WRn both low in A with CEn low; write edge while not IDLE (write ignored); aborted read.
- Simultaneous read and write edge in IDLE: neither strobe, error set, remain IDLE.

## Timing
- Edge k = first clk_usb edge sampling the strobe low with CEn low. `reg_write`/`reg_read` high between edges k+1 and k+2.
- `USB_Dout_oe` rises at edge k+1; `USB_Dout` valid from edge k+1+pRD_LATENCY; `fast_fifo_read` high for the cycle following that edge.
- SAM3U must hold RDn low at least pRD_LATENCY+3 cycles; oe drops one edge after RDn is sampled high.
- Min write cycle: strobe high for ≥2 cycles between accesses (edge detect needs B high).
- Reset values: all outputs 0, `USB_Dout`=0, state IDLE, counter 0. Reset mid-read: oe and all strobes 0 at the reset edge, no FIFO pop.

## Test plan
- Write addr 0x12, bytecnt 5, data 0xA5, WRn low 3 cycles -> exactly one `reg_write` pulse at k+1 with 0x12/5/0xA5; no `reg_read`.
- Read addr 0x20, `reg_datai`=0x3C, pRD_LATENCY=2, RDn low 6 cycles -> `reg_read` at k+1, oe at k+1, `USB_Dout`=0x3C from k+3, oe drops one edge after RDn high; `fast_fifo_read` never asserts.
- Four back-to-back reads at pFAST_ADDR with FIFO model -> four `fast_fifo_read` pulses, data words returned in order.
- RDn released at k+2 (before latency) -> oe 0 next edge, no data latch, no pop, `bus_error`=1.
- RDn and WRn low together -> no strobes, `bus_error`=1, held until reset.
- Assert reset at k+2 of a read -> oe, `USB_Dout`, `bus_error` 0; next read completes normally.
